// File: rtl/ysyx_exec_pkg.sv
// rtl/ysyx_exec_pkg.sv - shared widths and opcode enums for the RV32I execute datapath
package ysyx_exec_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RAW  = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

endpackage

// File: rtl/ysyx_exec_regfile.sv
// rtl/ysyx_exec_regfile.sv - 32x32 register file, x0 hardwired, async reads, optional debug port (YSYX_RF_DEBUG_EN)
module ysyx_exec_regfile
  import ysyx_exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [RAW-1:0]  waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RAW-1:0]  raddr1,
  input  logic [RAW-1:0]  raddr2,
`ifdef YSYX_RF_DEBUG_EN
  input  logic [RAW-1:0]  dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
`endif
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-through: a read in the write cycle sees the pre-edge value.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

`ifdef YSYX_RF_DEBUG_EN
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
`endif

endmodule

// File: rtl/ysyx_exec_datapath.sv
// rtl/ysyx_exec_datapath.sv - RV32I execute datapath: regfile, ALU, branch compare; YSYX_RF_DEBUG_EN adds a debug read port
module ysyx_exec_datapath
  import ysyx_exec_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rf_wr_en,
  input  logic [RAW-1:0]  rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic [RAW-1:0]  rf_raddr1,
  input  logic [RAW-1:0]  rf_raddr2,
  output logic [XLEN-1:0] rf_rdata1,
  output logic [XLEN-1:0] rf_rdata2,
`ifdef YSYX_RF_DEBUG_EN
  input  logic [RAW-1:0]  dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
`endif
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_func,
  output logic [XLEN-1:0] alu_out,
  input  logic [2:0]      br_type,
  output logic            br_taken
);

  ysyx_exec_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rf_wr_en),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr1    (rf_raddr1),
    .raddr2    (rf_raddr2),
`ifdef YSYX_RF_DEBUG_EN
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
`endif
    .rdata1    (rf_rdata1),
    .rdata2    (rf_rdata2)
  );

  logic [4:0] shamt;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_out = '0;
    case (alu_op_e'(alu_func))
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_SLL:   alu_out = alu_a << shamt;
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_SRL:   alu_out = alu_a >> shamt;
      ALU_SRA:   alu_out = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
  end

  // Compares the register operands directly, independent of the ALU operand muxing.
  always_comb begin
    br_taken = 1'b0;
    case (br_type_e'(br_type))
      BR_NONE: br_taken = 1'b0;
      BR_BEQ:  br_taken = (rf_rdata1 == rf_rdata2);
      BR_BNE:  br_taken = (rf_rdata1 != rf_rdata2);
      BR_BLT:  br_taken = ($signed(rf_rdata1) <  $signed(rf_rdata2));
      BR_BGE:  br_taken = ($signed(rf_rdata1) >= $signed(rf_rdata2));
      BR_BLTU: br_taken = (rf_rdata1 <  rf_rdata2);
      BR_BGEU: br_taken = (rf_rdata1 >= rf_rdata2);
      BR_JUMP: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_exec_datapath.sv
// tb/tb_ysyx_exec_datapath.sv - directed self-checking bench for ysyx_exec_datapath
module tb_ysyx_exec_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_wr_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_func;
  logic [31:0] alu_out;
  logic [2:0]  br_type;
  logic        br_taken;
`ifdef YSYX_RF_DEBUG_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_br;

  always #5 clk = ~clk;

  ysyx_exec_datapath dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rf_wr_en  (rf_wr_en),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
`ifdef YSYX_RF_DEBUG_EN
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_out   (alu_out),
    .br_type   (br_type),
    .br_taken  (br_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    alu_func = f;
    alu_a = a;
    alu_b = b;
    #1;
    check(tag, alu_out, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    rf_wr_en = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    alu_a = '0;
    alu_b = '0;
    alu_func = '0;
    br_type = '0;
`ifdef YSYX_RF_DEBUG_EN
    dbg_raddr = '0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 32; i++) begin
      rf_raddr1 = 5'(i);
      rf_raddr2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_x%0d", i), rf_rdata1, 32'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), rf_rdata2, 32'h0);
    end

    // Equal zero operands after reset: BEQ, BGE, BGEU, JUMP taken.
    exp_br = 8'b1101_0010;
    for (int t = 0; t < 8; t++) begin
      br_type = 3'(t);
      #1;
      check($sformatf("reset_br_%0d", t), {31'b0, br_taken}, {31'b0, exp_br[t]});
    end

    rf_wr_en = 1'b1;
    rf_waddr = 5'd0;
    rf_wdata = 32'hDEADBEEF;
    tick();
    rf_wr_en = 1'b0;
    rf_raddr1 = 5'd0;
    rf_raddr2 = 5'd0;
    #1;
    check("x0_write_rd1", rf_rdata1, 32'h0);
    check("x0_write_rd2", rf_rdata2, 32'h0);

    rf_wr_en = 1'b1;
    rf_waddr = 5'd5;
    rf_wdata = 32'hA5A5A5A5;
    tick();
    rf_wdata = 32'h12345678;
    rf_raddr1 = 5'd5;
    rf_raddr2 = 5'd5;
    #2;
    check("x5_same_cycle_old", rf_rdata1, 32'hA5A5A5A5);
    tick();
    rf_wr_en = 1'b0;
    #1;
    check("x5_after_edge_rd1", rf_rdata1, 32'h12345678);
    check("x5_after_edge_rd2", rf_rdata2, 32'h12345678);

    rst_n = 1'b0;
    rf_wr_en = 1'b1;
    rf_waddr = 5'd5;
    rf_wdata = 32'hCAFEF00D;
    tick();
    rst_n = 1'b1;
    rf_wr_en = 1'b0;
    #1;
    check("reset_blocks_write", rf_rdata1, 32'h0);

    alu_chk("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h1, 32'h0);
    alu_chk("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFFFFFF);
    alu_chk("slt_neg", 4'd3, 32'hFFFFFFFF, 32'h1, 32'h1);
    alu_chk("sltu_big", 4'd4, 32'hFFFFFFFF, 32'h1, 32'h0);
    alu_chk("sra", 4'd7, 32'h80000000, 32'h21, 32'hC0000000);
    alu_chk("srl", 4'd6, 32'h80000000, 32'h21, 32'h40000000);
    alu_chk("sll", 4'd2, 32'h80000000, 32'h21, 32'h0);
    alu_chk("passb", 4'd10, 32'h13572468, 32'hABCDE000, 32'hABCDE000);
    alu_chk("func12", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    alu_chk("xor", 4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    alu_chk("or", 4'd8, 32'hF0F0F0F0, 32'h0000FF00, 32'hF0F0FFF0);
    alu_chk("and", 4'd9, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    alu_chk("func15", 4'd15, 32'h12345678, 32'h1, 32'h0);

    rf_wr_en = 1'b1;
    rf_waddr = 5'd1;
    rf_wdata = 32'hFFFFFFFF;
    tick();
    rf_waddr = 5'd2;
    rf_wdata = 32'h1;
    tick();
    rf_wr_en = 1'b0;
    rf_raddr1 = 5'd1;
    rf_raddr2 = 5'd2;
    #1;
    check("x1_value", rf_rdata1, 32'hFFFFFFFF);
    check("x2_value", rf_rdata2, 32'h1);

    // A=-1, B=1: BNE, BLT, BGEU, JUMP taken.
    exp_br = 8'b1100_1100;
    for (int t = 0; t < 8; t++) begin
      br_type = 3'(t);
      #1;
      check($sformatf("br_%0d", t), {31'b0, br_taken}, {31'b0, exp_br[t]});
    end

    rf_raddr2 = 5'd1;
    br_type = 3'd1;
    #1;
    check("same_reg_rd2", rf_rdata2, 32'hFFFFFFFF);
    check("same_reg_beq", {31'b0, br_taken}, 32'h1);

`ifdef YSYX_RF_DEBUG_EN
    rf_wr_en = 1'b1;
    rf_waddr = 5'd31;
    rf_wdata = 32'h7;
    dbg_raddr = 5'd31;
    #1;
    check("dbg_x31_before", dbg_rdata, 32'h0);
    tick();
    rf_wr_en = 1'b0;
    check("dbg_x31", dbg_rdata, 32'h7);
    dbg_raddr = 5'd0;
    #1;
    check("dbg_x0", dbg_rdata, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
